// File: rtl/ripple_count_sampler_pkg.sv
// ---------------------------------------------------------------------------
// ripple_count_sampler_pkg
// Shared definitions for the ripple-counter sampler:
//   filt_state_t   - stability filter state (TRACK, HOLD)
//   DEF_CNT_W      - default width of the sampled ripple-counter value
//   DEF_EXT_W      - default width of the wrap-tracking extended count
//   DEF_STABLE_N   - default number of identical samples needed to accept
// ---------------------------------------------------------------------------
package ripple_count_sampler_pkg;

  typedef enum logic [0:0] {
    TRACK = 1'b0,
    HOLD  = 1'b1
  } filt_state_t;

  localparam int DEF_CNT_W    = 4;
  localparam int DEF_EXT_W    = 8;
  localparam int DEF_STABLE_N = 2;

endpackage

// File: rtl/sync2_bit.sv
// ---------------------------------------------------------------------------
// sync2_bit
// Two-flop synchronizer for one asynchronous bit.
// Ports:
//   clk  in  - sampling clock
//   rst  in  - asynchronous active-high reset (both stages cleared)
//   d    in  - asynchronous input bit
//   q1   out - first stage (possibly metastable, only for equality checks)
//   q2   out - second stage, safe synchronized value
// ---------------------------------------------------------------------------
module sync2_bit (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q1,
  output logic q2
);

  // Two-stage capture of the asynchronous bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q1 <= 1'b0;
      q2 <= 1'b0;
    end else begin
      q1 <= d;
      q2 <= q1;
    end
  end

endmodule

// File: rtl/ripple_count_sampler.sv
// ---------------------------------------------------------------------------
// ripple_count_sampler
// Samples an asynchronous ripple counter, accepts a value only after it has
// been seen identical for STABLE_N consecutive synchronized samples, and
// reports each accepted advance as a handshaked delta event while keeping an
// extended wrap-tracking running total.
// Ports:
//   clk        in   clock, all flops rising edge
//   rst        in   asynchronous active-high reset
//   cnt_in     in   raw ripple-counter bits (asynchronous)
//   out_ready  in   consumer accepts the pending event
//   clr_ovr    in   synchronous clear of the overrun flag
//   cnt_out    out  last accepted stable value
//   ext_cnt    out  running total of accepted deltas (mod 2^EXT_W)
//   delta      out  event payload: advance since last handshake (saturating)
//   out_valid  out  event pending
//   wrap_pulse out  one-cycle pulse when the accepted value wrapped below cnt_out
//   overrun    out  sticky: a change was accepted while an event was pending
// ---------------------------------------------------------------------------
module ripple_count_sampler
  import ripple_count_sampler_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int EXT_W    = DEF_EXT_W,
  parameter int STABLE_N = DEF_STABLE_N
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] cnt_in,
  input  logic             out_ready,
  input  logic             clr_ovr,
  output logic [CNT_W-1:0] cnt_out,
  output logic [EXT_W-1:0] ext_cnt,
  output logic [CNT_W-1:0] delta,
  output logic             out_valid,
  output logic             wrap_pulse,
  output logic             overrun
);

  localparam logic [2:0] RUN_LAST = 3'(STABLE_N - 1);

  logic [CNT_W-1:0] sync1_s;
  logic [CNT_W-1:0] sync2_s;

  for (genvar i = 0; i < CNT_W; i++) begin : g_sync
    sync2_bit u_sync (
      .clk (clk),
      .rst (rst),
      .d   (cnt_in[i]),
      .q1  (sync1_s[i]),
      .q2  (sync2_s[i])
    );
  end

  filt_state_t      state_r;
  logic [2:0]       run_r;

  logic             same_s;
  logic             accept_s;
  logic             change_s;
  logic             wrap_s;
  logic             pile_s;
  logic [CNT_W-1:0] d_s;
  logic [CNT_W:0]   sum_s;
  logic [CNT_W-1:0] sat_s;

  // Filter decision and event arithmetic for the current edge.
  always_comb begin
    // sync1 holds the value sync2 is about to load, so equality here means
    // sync2 will be unchanged from its previous-edge value after this edge.
    same_s = (sync1_s == sync2_s);
    if ((state_r == TRACK) && same_s && (run_r == RUN_LAST)) begin
      accept_s = 1'b1;
    end else begin
      accept_s = 1'b0;
    end
    change_s = accept_s && (sync2_s != cnt_out);
    wrap_s   = change_s && (sync2_s < cnt_out);
    d_s      = sync2_s - cnt_out;
    sum_s    = {1'b0, delta} + {1'b0, d_s};
    if (sum_s[CNT_W]) begin
      sat_s = {CNT_W{1'b1}};
    end else begin
      sat_s = sum_s[CNT_W-1:0];
    end
    pile_s = out_valid && !out_ready;
  end

  // Stability filter: count identical samples, then hold until a change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= TRACK;
      run_r   <= 3'd0;
    end else begin
      case (state_r)
        TRACK: begin
          if (!same_s) begin
            run_r <= 3'd0;
          end else if (run_r == RUN_LAST) begin
            state_r <= HOLD;
            run_r   <= 3'd0;
          end else begin
            run_r <= run_r + 3'd1;
          end
        end
        HOLD: begin
          if (!same_s) begin
            state_r <= TRACK;
            run_r   <= 3'd0;
          end else begin
            run_r <= 3'd0;
          end
        end
        default: begin
          state_r <= TRACK;
          run_r   <= 3'd0;
        end
      endcase
    end
  end

  // Accepted value, extended total and wrap pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_out    <= {CNT_W{1'b0}};
      ext_cnt    <= {EXT_W{1'b0}};
      wrap_pulse <= 1'b0;
    end else begin
      wrap_pulse <= wrap_s;
      if (change_s) begin
        cnt_out <= sync2_s;
        ext_cnt <= ext_cnt + {{(EXT_W-CNT_W){1'b0}}, d_s};
      end else begin
        cnt_out <= cnt_out;
        ext_cnt <= ext_cnt;
      end
    end
  end

  // Event handshake: fresh delta when free or consumed, else accumulate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      delta     <= {CNT_W{1'b0}};
      out_valid <= 1'b0;
    end else begin
      if (change_s && pile_s) begin
        delta     <= sat_s;
        out_valid <= 1'b1;
      end else if (change_s) begin
        delta     <= d_s;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        delta     <= delta;
        out_valid <= 1'b0;
      end else begin
        delta     <= delta;
        out_valid <= out_valid;
      end
    end
  end

  // Sticky overrun flag; a new overrun beats a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun <= 1'b0;
    end else begin
      if (change_s && pile_s) begin
        overrun <= 1'b1;
      end else if (clr_ovr) begin
        overrun <= 1'b0;
      end else begin
        overrun <= overrun;
      end
    end
  end

endmodule

// File: tb/tb_ripple_count_sampler.sv
// ---------------------------------------------------------------------------
// tb_ripple_count_sampler
// Self-checking bench: directed scenarios with literal expectations, then
// randomized traffic, all compared every cycle against a behavioural model.
// ---------------------------------------------------------------------------
module tb_ripple_count_sampler;

  localparam int CNT_W    = 4;
  localparam int EXT_W    = 8;
  localparam int STABLE_N = 2;
  localparam int CMOD     = 1 << CNT_W;
  localparam int EMOD     = 1 << EXT_W;

  logic             clk = 1'b0;
  logic             rst;
  logic [CNT_W-1:0] cnt_in;
  logic             out_ready;
  logic             clr_ovr;
  logic [CNT_W-1:0] cnt_out;
  logic [EXT_W-1:0] ext_cnt;
  logic [CNT_W-1:0] delta;
  logic             out_valid;
  logic             wrap_pulse;
  logic             overrun;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Behavioural model state: expected outputs plus a run of raw samples.
  int m_cnt, m_ext, m_delta, m_valid, m_wrap, m_ovr;
  int run_val, run_len;
  int m_val, m_d, m_set, m_sample;

  always #5 clk = ~clk;

  ripple_count_sampler #(
    .CNT_W    (CNT_W),
    .EXT_W    (EXT_W),
    .STABLE_N (STABLE_N)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cnt_in     (cnt_in),
    .out_ready  (out_ready),
    .clr_ovr    (clr_ovr),
    .cnt_out    (cnt_out),
    .ext_cnt    (ext_cnt),
    .delta      (delta),
    .out_valid  (out_valid),
    .wrap_pulse (wrap_pulse),
    .overrun    (overrun)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a value is accepted once the raw samples seen so far end in a run
  // of exactly STABLE_N+1 identical values (the two synchronizer stages
  // start as two samples of 0 after reset).
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt = 0; m_ext = 0; m_delta = 0; m_valid = 0; m_wrap = 0; m_ovr = 0;
      run_val = 0; run_len = 2;
    end else begin
      m_val    = run_val;
      m_sample = int'(cnt_in);
      m_wrap   = 0;
      m_set    = 0;
      if (run_len == STABLE_N + 1 && m_val != m_cnt) begin
        m_d    = (m_val - m_cnt + CMOD) % CMOD;
        m_wrap = (m_val < m_cnt) ? 1 : 0;
        m_ext  = (m_ext + m_d) % EMOD;
        m_cnt  = m_val;
        if (m_valid == 1 && !out_ready) begin
          m_delta = (m_delta + m_d > CMOD - 1) ? CMOD - 1 : m_delta + m_d;
          m_set   = 1;
        end else begin
          m_delta = m_d;
        end
        m_valid = 1;
      end else if (m_valid == 1 && out_ready) begin
        m_valid = 0;
      end
      if (m_set == 1) m_ovr = 1;
      else if (clr_ovr) m_ovr = 0;
      if (m_sample == run_val) begin
        if (run_len < 100) run_len = run_len + 1;
      end else begin
        run_val = m_sample;
        run_len = 1;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cnt_out", int'(cnt_out), m_cnt);
      chk("ext_cnt", int'(ext_cnt), m_ext);
      chk("delta", int'(delta), m_delta);
      chk("out_valid", int'(out_valid), m_valid);
      chk("wrap_pulse", int'(wrap_pulse), m_wrap);
      chk("overrun", int'(overrun), m_ovr);
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cnt_out"}, int'(cnt_out), 0);
    chk({tag, "_ext_cnt"}, int'(ext_cnt), 0);
    chk({tag, "_delta"}, int'(delta), 0);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_wrap"}, int'(wrap_pulse), 0);
    chk({tag, "_overrun"}, int'(overrun), 0);
  endtask

  initial begin
    logic [CNT_W-1:0] saved;
    rst = 1'b1; cnt_in = 4'd0; out_ready = 1'b1; clr_ovr = 1'b0;
    wait_cycles(3);
    chk_all_zero("reset");
    cmp_en = 1'b1;
    rst = 1'b0;
    wait_cycles(5);

    // First event 0->1: lands on edge 4 after the change.
    cnt_in = 4'd1;
    wait_cycles(3);
    chk("lat_not_yet", int'(out_valid), 0);
    wait_cycles(1);
    chk("first_cnt", int'(cnt_out), 1);
    chk("first_delta", int'(delta), 1);
    chk("first_valid", int'(out_valid), 1);
    chk("first_ext", int'(ext_cnt), 1);

    // Wrap from 14 to 2.
    cnt_in = 4'd14;
    wait_cycles(6);
    chk("at14_ext", int'(ext_cnt), 14);
    cnt_in = 4'd2;
    wait_cycles(4);
    chk("wrap_delta", int'(delta), 4);
    chk("wrap_pulse_hi", int'(wrap_pulse), 1);
    chk("wrap_ext", int'(ext_cnt), 18);
    chk("wrap_cnt", int'(cnt_out), 2);
    wait_cycles(1);
    chk("wrap_pulse_lo", int'(wrap_pulse), 0);

    // One-cycle glitch 3->7->3 must be ignored.
    cnt_in = 4'd3;
    wait_cycles(6);
    chk("pre_glitch_ext", int'(ext_cnt), 19);
    cnt_in = 4'd7;
    wait_cycles(1);
    cnt_in = 4'd3;
    for (int i = 0; i < 8; i++) begin
      wait_cycles(1);
      chk("glitch_cnt", int'(cnt_out), 3);
      chk("glitch_valid", int'(out_valid), 0);
    end

    // Overrun: 0->3 then 3->5 with consumer stalled.
    cnt_in = 4'd0;
    wait_cycles(6);
    chk("zero_ext", int'(ext_cnt), 32);
    out_ready = 1'b0;
    cnt_in = 4'd3;
    wait_cycles(6);
    chk("ovr_first_delta", int'(delta), 3);
    chk("ovr_first_flag", int'(overrun), 0);
    cnt_in = 4'd5;
    wait_cycles(6);
    chk("ovr_delta", int'(delta), 5);
    chk("ovr_flag", int'(overrun), 1);
    chk("ovr_ext", int'(ext_cnt), 37);
    clr_ovr = 1'b1;
    wait_cycles(1);
    clr_ovr = 1'b0;
    chk("ovr_cleared", int'(overrun), 0);
    chk("ovr_still_valid", int'(out_valid), 1);

    // Saturation: 5 + 8 + 8 + 4 exceeds 15.
    cnt_in = 4'd13;
    wait_cycles(6);
    cnt_in = 4'd5;
    wait_cycles(6);
    cnt_in = 4'd9;
    wait_cycles(6);
    chk("sat_delta", int'(delta), 15);
    chk("sat_ext", int'(ext_cnt), 57);
    chk("sat_cnt", int'(cnt_out), 9);
    chk("sat_ovr", int'(overrun), 1);

    // Reset while an event is pending, then 9 reported from 0.
    #2 rst = 1'b1;
    #1 chk_all_zero("midrst");
    cnt_in = 4'd9;
    out_ready = 1'b1;
    wait_cycles(1);
    rst = 1'b0;
    wait_cycles(3);
    chk("post_rst_early", int'(out_valid), 0);
    wait_cycles(1);
    chk("post_rst_valid", int'(out_valid), 1);
    chk("post_rst_delta", int'(delta), 9);
    chk("post_rst_ext", int'(ext_cnt), 9);

    // Randomized traffic checked by the model.
    for (int i = 0; i < 4000; i++) begin
      wait_cycles(1);
      out_ready = ($urandom_range(0, 3) != 0);
      clr_ovr   = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 99))
        0, 1, 2, 3, 4, 5, 6, 7: cnt_in = 4'($urandom);
        8, 9: begin
          saved  = cnt_in;
          cnt_in = 4'($urandom);
          wait_cycles(1);
          cnt_in = saved;
        end
        10: if ($urandom_range(0, 7) == 0) begin
          #2 rst = 1'b1;
          #4 rst = 1'b0;
        end
        default: cnt_in = cnt_in;
      endcase
    end

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ripple_count_sampler.md
RIPPLE_COUNT_SAMPLER -- requirements
Module: ripple_count_sampler

Interface
REQ-001 Parameter CNT_W, default 4: width of the asynchronous ripple-counter value sampled.
REQ-002 Parameter EXT_W, default 8: width of the extended (wrap-tracking) count; SHALL be > CNT_W.
REQ-003 Parameter STABLE_N, default 2, legal range 1..7: consecutive identical synchronized samples required to accept a value.
REQ-004 clk  in  1: single clock; all flops rising-edge.
REQ-005 rst  in  1: reset, asynchronous, active-high.
REQ-006 cnt_in  in  CNT_W: raw ripple-counter outputs, asynchronous to clk; bit 0 is the fastest-toggling stage.
REQ-007 out_ready  in  1: consumer accepts the current event when high with out_valid.
REQ-008 clr_ovr  in  1: synchronous clear of the overrun flag.
REQ-009 cnt_out  out  CNT_W: last accepted stable value.
REQ-010 ext_cnt  out  EXT_W: running total, advanced by each accepted delta, modulo 2^EXT_W.
REQ-011 delta  out  CNT_W: event payload, the count advance since the last handshake.
REQ-012 out_valid  out  1: event pending.
REQ-013 wrap_pulse  out  1: one-cycle pulse when an accepted value is numerically below the previous cnt_out.
REQ-014 overrun  out  1: sticky; an accepted change arrived while an event was pending.

Function
REQ-015 Each cnt_in bit SHALL pass through a 2-flop synchronizer (sync1, sync2) before any other use.
REQ-016 Stability filter FSM: states TRACK and HOLD; run counter of 3 bits.
REQ-017 TRACK: on each edge, if sync2 equals its value from the previous edge, the run counter increments, else it clears.
REQ-018 When the run counter reaches STABLE_N-1 and the equality holds, the sync2 value SHALL be accepted and the FSM SHALL enter HOLD.
REQ-019 HOLD: remain while sync2 is unchanged; any change returns to TRACK with the run counter at 0.
REQ-020 Accepting a value equal to cnt_out SHALL produce no event, no delta and no pulse.
REQ-021 Accepting a value v different from cnt_out: d = (v - cnt_out) mod 2^CNT_W; cnt_out <= v; ext_cnt <= ext_cnt + d (zero-extended); wrap_pulse high for one cycle if v < cnt_out.
REQ-022 Latency: if cnt_in settles before edge 1 and then holds, cnt_out and out_valid SHALL update at edge STABLE_N+2. Edge 1 is the first edge at which sync1 captures the new value.
REQ-023 Output handshake: when out_valid=0, an accepted change sets delta=d and out_valid=1.
REQ-024 An event is consumed on an edge where out_valid=1 and out_ready=1; out_valid drops unless a new change is accepted on that same edge, in which case delta <= d and out_valid stays 1.
REQ-025 A change accepted while out_valid=1 and out_ready=0 SHALL set delta <= min(delta + d, 2^CNT_W-1) (saturating) and set overrun.
REQ-026 delta and cnt_out SHALL be stable while out_valid=1 and out_ready=0, except as updated by REQ-025.
REQ-027 clr_ovr clears overrun; if it coincides with a REQ-025 event, the set SHALL win.

Reset
REQ-028 rst asserted SHALL asynchronously force: synchronizers 0, run counter 0, FSM TRACK, cnt_out 0, ext_cnt 0, delta 0, out_valid 0, wrap_pulse 0, overrun 0.
REQ-029 Reset asserted mid-event SHALL discard the pending event without a handshake; the first post-reset accepted nonzero value SHALL be reported as an event from 0.

Structure
REQ-030 A shared package SHALL hold the filter state enum (TRACK, HOLD) and default constants for CNT_W, EXT_W and STABLE_N.
REQ-031 A sub-module sync2_bit SHALL be instantiated CNT_W times for the synchronizer; the remaining logic SHALL stay in the top level.

Verification
REQ-032 Reset, then cnt_in 0->1 held, out_ready=1, STABLE_N=2 -> at edge 4 cnt_out=1, delta=1, out_valid=1, ext_cnt=1.
REQ-033 A 1-cycle glitch of cnt_in 3->7->3 -> no acceptance of 7, and no event is issued.
REQ-034 cnt_out=14, then cnt_in=2 stable -> delta=4, wrap_pulse for one cycle, ext_cnt advances by 4.
REQ-035 out_ready=0; changes 0->3 then 3->5 -> delta=5, overrun=1; after clr_ovr, overrun=0.
REQ-036 out_ready=0; accumulated deltas exceed 15 -> delta saturates at 15, while ext_cnt stays exact.
REQ-037 rst asserted with out_valid=1 -> all outputs 0 immediately; with cnt_in=9 held, an event with delta=9 follows.
